// File: rtl/div_issue_queue.sv
// Request FIFO and sequencer around an iterative go/done divider: issues one
// request at a time, resolves divide-by-zero locally and times out a hung core.
module div_issue_queue #(
  parameter int W       = 32,
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_left,
  input  logic [W-1:0]     in_right,
  input  logic [TAG_W-1:0] in_tag,
  output logic             div_go,
  output logic [W-1:0]     div_left,
  output logic [W-1:0]     div_right,
  input  logic             div_done,
  input  logic [W-1:0]     div_quotient,
  input  logic [W-1:0]     div_remainder,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_quotient,
  output logic [W-1:0]     out_remainder,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_dbz,
  output logic             out_err
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int WD_W  = $clog2(TIMEOUT + 1);
  localparam int ENT_W = TAG_W + 2 * W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t             state_r, state_s;
  logic [ENT_W-1:0]   fifo_mem_r [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0]   count_r, count_s;
  logic               in_ready_r;
  logic               push_s, pop_s;
  logic [ENT_W-1:0]   head_s;
  logic [W-1:0]       head_left_s, head_right_s;
  logic [TAG_W-1:0]   head_tag_s;
  logic [WD_W-1:0]    wd_r, wd_s;
  logic [W-1:0]       op_left_r, op_left_s, op_right_r, op_right_s;
  logic [TAG_W-1:0]   op_tag_r, op_tag_s;
  logic [W-1:0]       res_q_r, res_q_s, res_r_r, res_r_s;
  logic [TAG_W-1:0]   res_tag_r, res_tag_s;
  logic               res_dbz_r, res_dbz_s, res_err_r, res_err_s;
  logic               out_valid_r, out_valid_s;
  logic               div_go_r, div_go_s;

  assign push_s       = in_valid && in_ready_r;
  assign head_s       = fifo_mem_r[rd_ptr_r];
  assign head_left_s  = head_s[W-1:0];
  assign head_right_s = head_s[2*W-1:W];
  assign head_tag_s   = head_s[ENT_W-1:2*W];

  // Occupancy after this cycle's push/pop; in_ready is registered from it.
  always_comb begin
    count_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_s = count_r + CNT_W'(1);
      2'b01:   count_s = count_r - CNT_W'(1);
      default: count_s = count_r;
    endcase
  end

  // Sequencer next-state and next values for operand/result registers.
  always_comb begin
    state_s     = state_r;
    wd_s        = wd_r;
    op_left_s   = op_left_r;
    op_right_s  = op_right_r;
    op_tag_s    = op_tag_r;
    res_q_s     = res_q_r;
    res_r_s     = res_r_r;
    res_tag_s   = res_tag_r;
    res_dbz_s   = res_dbz_r;
    res_err_s   = res_err_r;
    out_valid_s = out_valid_r;
    div_go_s    = 1'b0;
    pop_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (count_r != CNT_W'(0)) begin
          pop_s = 1'b1;
          if (head_right_s == {W{1'b0}}) begin
            res_q_s     = {W{1'b1}};
            res_r_s     = head_left_s;
            res_tag_s   = head_tag_s;
            res_dbz_s   = 1'b1;
            res_err_s   = 1'b0;
            out_valid_s = 1'b1;
            state_s     = RESP;
          end else begin
            op_left_s  = head_left_s;
            op_right_s = head_right_s;
            op_tag_s   = head_tag_s;
            div_go_s   = 1'b1;
            state_s    = ISSUE;
          end
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        wd_s    = {WD_W{1'b0}};
        state_s = WAIT;
      end
      WAIT: begin
        if (div_done) begin
          res_q_s     = div_quotient;
          res_r_s     = div_remainder;
          res_tag_s   = op_tag_r;
          res_dbz_s   = 1'b0;
          res_err_s   = 1'b0;
          out_valid_s = 1'b1;
          state_s     = RESP;
        end else if (wd_r == WD_W'(TIMEOUT - 1)) begin
          // Hung core: report an error with zeroed data rather than stall forever.
          res_q_s     = {W{1'b0}};
          res_r_s     = {W{1'b0}};
          res_tag_s   = op_tag_r;
          res_dbz_s   = 1'b0;
          res_err_s   = 1'b1;
          out_valid_s = 1'b1;
          state_s     = RESP;
        end else begin
          wd_s = wd_r + WD_W'(1);
        end
      end
      RESP: begin
        if (out_ready) begin
          out_valid_s = 1'b0;
          state_s     = IDLE;
        end else begin
          out_valid_s = 1'b1;
        end
      end
      default: begin
        out_valid_s = 1'b0;
        state_s     = IDLE;
      end
    endcase
  end

  // Control, operand and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      wr_ptr_r    <= {PTR_W{1'b0}};
      rd_ptr_r    <= {PTR_W{1'b0}};
      count_r     <= {CNT_W{1'b0}};
      in_ready_r  <= 1'b1;
      wd_r        <= {WD_W{1'b0}};
      op_left_r   <= {W{1'b0}};
      op_right_r  <= {W{1'b0}};
      op_tag_r    <= {TAG_W{1'b0}};
      res_q_r     <= {W{1'b0}};
      res_r_r     <= {W{1'b0}};
      res_tag_r   <= {TAG_W{1'b0}};
      res_dbz_r   <= 1'b0;
      res_err_r   <= 1'b0;
      out_valid_r <= 1'b0;
      div_go_r    <= 1'b0;
    end else begin
      state_r     <= state_s;
      wr_ptr_r    <= push_s ? wr_ptr_r + PTR_W'(1) : wr_ptr_r;
      rd_ptr_r    <= pop_s ? rd_ptr_r + PTR_W'(1) : rd_ptr_r;
      count_r     <= count_s;
      in_ready_r  <= (count_s != CNT_W'(DEPTH));
      wd_r        <= wd_s;
      op_left_r   <= op_left_s;
      op_right_r  <= op_right_s;
      op_tag_r    <= op_tag_s;
      res_q_r     <= res_q_s;
      res_r_r     <= res_r_s;
      res_tag_r   <= res_tag_s;
      res_dbz_r   <= res_dbz_s;
      res_err_r   <= res_err_s;
      out_valid_r <= out_valid_s;
      div_go_r    <= div_go_s;
    end
  end

  // FIFO storage: {tag, right, left} per entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_mem_r[i] <= {ENT_W{1'b0}};
      end
    end else if (push_s) begin
      fifo_mem_r[wr_ptr_r] <= {in_tag, in_right, in_left};
    end else begin
      fifo_mem_r[wr_ptr_r] <= fifo_mem_r[wr_ptr_r];
    end
  end

  assign in_ready      = in_ready_r;
  assign div_go        = div_go_r;
  assign div_left      = op_left_r;
  assign div_right     = op_right_r;
  assign out_valid     = out_valid_r;
  assign out_quotient  = res_q_r;
  assign out_remainder = res_r_r;
  assign out_tag       = res_tag_r;
  assign out_dbz       = res_dbz_r;
  assign out_err       = res_err_r;

endmodule

// File: tb/tb_div_issue_queue.sv
// Bench for div_issue_queue: behavioural iterative divider, scoreboarded results,
// table-driven single requests plus backpressure, hold, timeout and reset sequences.
module tb_div_issue_queue;
  localparam int W = 32, DEPTH = 4, TAG_W = 4, TIMEOUT = 64, LAT = W + 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0, in_ready;
  logic [W-1:0] in_left = '0, in_right = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic div_go, div_done = 1'b0;
  logic [W-1:0] div_left, div_right, div_quotient = '0, div_remainder = '0;
  logic out_valid, out_ready = 1'b1, out_dbz, out_err;
  logic [W-1:0] out_quotient, out_remainder;
  logic [TAG_W-1:0] out_tag;

  div_issue_queue #(.W(W), .DEPTH(DEPTH), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_left(in_left), .in_right(in_right), .in_tag(in_tag),
    .div_go(div_go), .div_left(div_left), .div_right(div_right),
    .div_done(div_done), .div_quotient(div_quotient), .div_remainder(div_remainder),
    .out_valid(out_valid), .out_ready(out_ready), .out_quotient(out_quotient),
    .out_remainder(out_remainder), .out_tag(out_tag), .out_dbz(out_dbz), .out_err(out_err));

  always #5 clk = ~clk;

  typedef struct { logic [W-1:0] q; logic [W-1:0] r; logic [TAG_W-1:0] tag; logic dbz; logic err; } exp_t;
  typedef struct { logic [W-1:0] l; logic [W-1:0] r; logic [TAG_W-1:0] tag;
                   logic [W-1:0] q; logic [W-1:0] rem; logic dbz; } vec_t;

  exp_t sb_q[$];
  int checks = 0, failures = 0;
  bit hang = 1'b0, stray_req = 1'b0;

  // Divider model: samples operands on div_go, answers LAT cycles later unless hung.
  logic [W-1:0] m_l, m_r;
  int m_cnt;
  bit m_busy = 1'b0;
  always @(negedge clk) begin
    div_done = 1'b0;
    if (reset) begin
      m_busy = 1'b0;
    end else if (stray_req) begin
      div_done = 1'b1; div_quotient = 32'hDEAD_BEEF; div_remainder = 32'h1234_5678;
    end else if (m_busy && !hang) begin
      if (m_cnt == 0) begin
        div_done = 1'b1;
        div_quotient  = (m_r == '0) ? '0 : m_l / m_r;
        div_remainder = (m_r == '0) ? '0 : m_l % m_r;
        m_busy = 1'b0;
      end else begin
        m_cnt--;
      end
    end
    if (div_go && !reset) begin
      m_busy = 1'b1; m_cnt = LAT - 1; m_l = div_left; m_r = div_right;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [W-1:0] l, input logic [W-1:0] r,
                              input logic [TAG_W-1:0] tag, input bit err);
    exp_t e;
    e.tag = tag; e.err = err; e.dbz = 1'b0;
    if (err) begin e.q = '0; e.r = '0; end
    else if (r == '0) begin e.q = {W{1'b1}}; e.r = l; e.dbz = 1'b1; end
    else begin e.q = l / r; e.r = l % r; end
    return e;
  endfunction

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_result_tag", {60'd0, out_tag}, 64'hFFFF);
        end else begin
          e = sb_q.pop_front();
          chk("out_quotient", {32'd0, out_quotient}, {32'd0, e.q});
          chk("out_remainder", {32'd0, out_remainder}, {32'd0, e.r});
          chk("out_tag", {60'd0, out_tag}, {60'd0, e.tag});
          chk("out_dbz", {63'd0, out_dbz}, {63'd0, e.dbz});
          chk("out_err", {63'd0, out_err}, {63'd0, e.err});
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Offer one request; returns one cycle after the accepting edge.
  task automatic send(input logic [W-1:0] l, input logic [W-1:0] r,
                      input logic [TAG_W-1:0] tag, input exp_t e, output int waits);
    bit ok = 1'b0;
    waits = 0;
    in_valid = 1'b1; in_left = l; in_right = r; in_tag = tag;
    for (int n = 0; n < 300 && !ok; n++) begin
      @(negedge clk);
      if (in_ready) begin sb_q.push_back(e); ok = 1'b1; end
      else waits++;
      tick();
    end
    in_valid = 1'b0;
    if (!ok) chk("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 500 && sb_q.size() != 0; n++) tick();
    chk("drain_remaining", 64'(sb_q.size()), 64'd0);
    tick(); tick();
  endtask

  vec_t vecs[7];
  int waits, go_at, ov_at, cnt_a, cnt_b;
  logic [W-1:0] snap_q, snap_r;
  logic [TAG_W-1:0] snap_tag;
  bit stable, all_immediate;

  initial begin
    vecs[0] = '{32'd100, 32'd7, 4'd3, 32'd14, 32'd2, 1'b0};
    vecs[1] = '{32'd5, 32'd0, 4'd1, 32'hFFFF_FFFF, 32'd5, 1'b1};
    vecs[2] = '{32'd0, 32'd9, 4'd4, 32'd0, 32'd0, 1'b0};
    vecs[3] = '{32'hFFFF_FFFF, 32'd1, 4'd7, 32'hFFFF_FFFF, 32'd0, 1'b0};
    vecs[4] = '{32'd7, 32'd100, 4'd10, 32'd0, 32'd7, 1'b0};
    vecs[5] = '{32'h8000_0000, 32'd3, 4'd11, 32'h2AAA_AAAA, 32'd2, 1'b0};
    vecs[6] = '{32'd0, 32'd0, 4'd12, 32'hFFFF_FFFF, 32'd0, 1'b1};
    fork monitor(); join_none

    tick(); tick();
    @(negedge clk);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_div_go", {63'd0, div_go}, 64'd0);
    chk("rst_out_data", {out_quotient, out_remainder}, 64'd0);
    chk("rst_flags", {58'd0, out_tag, out_dbz, out_err}, 64'd0);
    tick();
    reset = 1'b0;
    tick();

    // Table: one request at a time, latency to issue / dbz result.
    foreach (vecs[i]) begin
      exp_t e;
      e.q = vecs[i].q; e.r = vecs[i].rem; e.tag = vecs[i].tag; e.dbz = vecs[i].dbz; e.err = 1'b0;
      send(vecs[i].l, vecs[i].r, vecs[i].tag, e, waits);
      go_at = -1; ov_at = -1;
      for (int k = 1; k <= 3; k++) begin
        @(negedge clk);
        if (div_go && go_at < 0) go_at = k;
        if (out_valid && ov_at < 0) ov_at = k;
        tick();
      end
      if (vecs[i].dbz) begin
        chk("dbz_latency", 64'(ov_at), 64'd2);
        chk("dbz_no_go", 64'(go_at), 64'(-1));
      end else begin
        chk("issue_latency", 64'(go_at), 64'd2);
      end
      wait_drain();
    end

    // Backpressure: one request in flight plus DEPTH queued fills the block.
    out_ready = 1'b0;
    all_immediate = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send(32'(100 + i * 37), 32'(i + 3), 4'(8 + i), mk(32'(100 + i * 37), 32'(i + 3), 4'(8 + i), 1'b0), waits);
      if (waits != 0) all_immediate = 1'b0;
    end
    chk("first5_immediate", {63'd0, all_immediate}, 64'd1);
    @(negedge clk);
    chk("full_in_ready", {63'd0, in_ready}, 64'd0);
    tick();
    out_ready = 1'b1;
    send(32'd999, 32'd10, 4'd13, mk(32'd999, 32'd10, 4'd13, 1'b0), waits);
    wait_drain();

    // Hold in RESP: outputs stable, stray div_done ignored, next issue after handshake.
    out_ready = 1'b0;
    send(32'd20, 32'd3, 4'd5, mk(32'd20, 32'd3, 4'd5, 1'b0), waits);
    send(32'd9, 32'd2, 4'd6, mk(32'd9, 32'd2, 4'd6, 1'b0), waits);
    for (int n = 0; n < 100 && !out_valid; n++) tick();
    @(negedge clk);
    chk("hold_valid", {63'd0, out_valid}, 64'd1);
    snap_q = out_quotient; snap_r = out_remainder; snap_tag = out_tag;
    stable = 1'b1; cnt_a = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      stray_req = (k == 3);
      @(negedge clk);
      if (!out_valid || out_quotient !== snap_q || out_remainder !== snap_r || out_tag !== snap_tag)
        stable = 1'b0;
      if (div_go) cnt_a++;
    end
    stray_req = 1'b0;
    chk("hold_stable", {63'd0, stable}, 64'd1);
    chk("hold_no_go", 64'(cnt_a), 64'd0);
    tick();
    out_ready = 1'b1;
    @(negedge clk);
    go_at = -1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (div_go && go_at < 0) go_at = k;
    end
    chk("post_handshake_issue", 64'(go_at), 64'd2);
    wait_drain();

    // Watchdog: hung divider gives err result TIMEOUT+1 cycles after div_go.
    hang = 1'b1;
    send(32'd50, 32'd5, 4'd2, mk(32'd50, 32'd5, 4'd2, 1'b1), waits);
    go_at = -1; ov_at = -1;
    for (int k = 1; k < 150 && ov_at < 0; k++) begin
      @(negedge clk);
      if (div_go && go_at < 0) go_at = k;
      if (out_valid && ov_at < 0) ov_at = k;
    end
    chk("timeout_latency", 64'(ov_at - go_at), 64'(TIMEOUT + 1));
    tick();
    wait_drain();

    // Reset during WAIT with two queued requests: nothing stale survives.
    send(32'd77, 32'd7, 4'd9, mk(32'd77, 32'd7, 4'd9, 1'b1), waits);
    send(32'd40, 32'd4, 4'd14, mk(32'd40, 32'd4, 4'd14, 1'b0), waits);
    send(32'd41, 32'd4, 4'd15, mk(32'd41, 32'd4, 4'd15, 1'b0), waits);
    tick(); tick();
    reset = 1'b1;
    sb_q.delete();
    tick();
    @(negedge clk);
    chk("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    tick();
    reset = 1'b0;
    hang = 1'b0;
    cnt_a = 0; cnt_b = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (out_valid) cnt_a++;
      if (div_go) cnt_b++;
    end
    chk("post_rst_no_result", 64'(cnt_a), 64'd0);
    chk("post_rst_no_go", 64'(cnt_b), 64'd0);
    tick();

    // Recovery after reset.
    send(32'd100, 32'd7, 4'd3, mk(32'd100, 32'd7, 4'd3, 1'b0), waits);
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
